// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external ALU between two requesters.
// Operations are granted round-robin, executed from registered operands in a
// single EXEC cycle, and the captured result is held for the owning requester
// until it completes its response handshake.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  req0Valid,
  output logic                  req0Ready,
  input  logic [DATA_WIDTH-1:0] req0SrcA,
  input  logic [DATA_WIDTH-1:0] req0SrcB,
  input  logic [2:0]            req0AluControl,
  output logic                  rsp0Valid,
  input  logic                  rsp0Ready,
  output logic [DATA_WIDTH-1:0] rsp0Result,

  input  logic                  req1Valid,
  output logic                  req1Ready,
  input  logic [DATA_WIDTH-1:0] req1SrcA,
  input  logic [DATA_WIDTH-1:0] req1SrcB,
  input  logic [2:0]            req1AluControl,
  output logic                  rsp1Valid,
  input  logic                  rsp1Ready,
  output logic [DATA_WIDTH-1:0] rsp1Result,

  output logic [DATA_WIDTH-1:0] aluSrcA,
  output logic [DATA_WIDTH-1:0] aluSrcB,
  output logic [2:0]            aluControl,
  input  logic [DATA_WIDTH-1:0] aluResult,

  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_owner;
  logic                  r_prio;
  logic [DATA_WIDTH-1:0] r_opA;
  logic [DATA_WIDTH-1:0] r_opB;
  logic [2:0]            r_opCtl;
  logic [DATA_WIDTH-1:0] r_result;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;
  logic w_accept0;
  logic w_accept1;
  logic w_rspAccept;

  assign w_idle = (r_state == IDLE);

  // Grant selection: a lone requester wins outright, contention goes to prio.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (req0Valid && req1Valid) begin
      w_grant0 = ~r_prio;
      w_grant1 = r_prio;
    end else begin
      w_grant0 = req0Valid;
      w_grant1 = req1Valid;
    end
  end

  // Ready is forced low while reset is asserted so nothing looks accepted
  // during an abort, even though the reset state is IDLE.
  assign req0Ready = rst_n && w_idle && w_grant0;
  assign req1Ready = rst_n && w_idle && w_grant1;

  assign w_accept0 = req0Valid && req0Ready;
  assign w_accept1 = req1Valid && req1Ready;

  // Only the owner's ready can close a response.
  assign w_rspAccept = r_owner ? rsp1Ready : rsp0Ready;

  // Sequencer: latch the granted operation, run one EXEC cycle, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_owner  <= 1'b0;
      r_prio   <= 1'b0;
      r_opA    <= '0;
      r_opB    <= '0;
      r_opCtl  <= 3'b000;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept0) begin
            r_opA   <= req0SrcA;
            r_opB   <= req0SrcB;
            r_opCtl <= req0AluControl;
            r_owner <= 1'b0;
            r_state <= EXEC;
          end else if (w_accept1) begin
            r_opA   <= req1SrcA;
            r_opB   <= req1SrcB;
            r_opCtl <= req1AluControl;
            r_owner <= 1'b1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_result <= aluResult;
          r_state  <= RESP;
        end
        RESP: begin
          if (w_rspAccept) begin
            r_prio  <= ~r_owner;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rsp0Valid  = (r_state == RESP) && !r_owner;
  assign rsp1Valid  = (r_state == RESP) && r_owner;
  assign rsp0Result = r_result;
  assign rsp1Result = r_result;

  assign aluSrcA    = r_opA;
  assign aluSrcB    = r_opB;
  assign aluControl = r_opCtl;

  assign busy = !w_idle;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed scenarios for the shared-ALU arbiter, with a
// behavioural ALU attached to the ALU-side ports.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0Valid, req0Ready, rsp0Valid, rsp0Ready;
  logic [31:0] req0SrcA, req0SrcB, rsp0Result;
  logic [2:0]  req0AluControl;
  logic        req1Valid, req1Ready, rsp1Valid, rsp1Ready;
  logic [31:0] req1SrcA, req1SrcB, rsp1Result;
  logic [2:0]  req1AluControl;
  logic [31:0] aluSrcA, aluSrcB, aluResult;
  logic [2:0]  aluControl;
  logic        busy;

  int nCompared;
  int nMismatched;

  alu_share_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0Valid(req0Valid), .req0Ready(req0Ready), .req0SrcA(req0SrcA),
    .req0SrcB(req0SrcB), .req0AluControl(req0AluControl),
    .rsp0Valid(rsp0Valid), .rsp0Ready(rsp0Ready), .rsp0Result(rsp0Result),
    .req1Valid(req1Valid), .req1Ready(req1Ready), .req1SrcA(req1SrcA),
    .req1SrcB(req1SrcB), .req1AluControl(req1AluControl),
    .rsp1Valid(rsp1Valid), .rsp1Ready(rsp1Ready), .rsp1Result(rsp1Result),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluControl(aluControl),
    .aluResult(aluResult), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU stand-in driven by the arbiter's registered operands.
  always_comb begin
    aluResult = 32'h0;
    case (aluControl)
      3'b000: aluResult = aluSrcA + aluSrcB;
      3'b001: aluResult = aluSrcA - aluSrcB;
      3'b010: aluResult = aluSrcA & aluSrcB;
      3'b011: aluResult = aluSrcA | aluSrcB;
      3'b100: aluResult = aluSrcB;
      3'b101: aluResult = {31'b0, ($signed(aluSrcA) < $signed(aluSrcB))};
      3'b110: aluResult = aluSrcA << aluSrcB[4:0];
      default: aluResult = aluSrcA >> aluSrcB[4:0];
    endcase
  end

  // Reset state with both requesters asserting valid.
  task automatic test_reset();
    rst_n = 1'b0;
    req0Valid = 1'b1; req1Valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    nCompared++; if (req0Ready !== 1'b0 || req1Ready !== 1'b0) begin nMismatched++; $display("FAIL reset_ready got=%b%b want=00", req0Ready, req1Ready); end
    nCompared++; if (rsp0Valid !== 1'b0 || rsp1Valid !== 1'b0 || busy !== 1'b0) begin nMismatched++; $display("FAIL reset_valid_busy got=%b%b%b want=000", rsp0Valid, rsp1Valid, busy); end
    nCompared++; if (aluSrcA !== 32'h0 || aluSrcB !== 32'h0 || aluControl !== 3'b000) begin nMismatched++; $display("FAIL reset_alu got=%h %h %b want=0 0 000", aluSrcA, aluSrcB, aluControl); end
    nCompared++; if (rsp0Result !== 32'h0 || rsp1Result !== 32'h0) begin nMismatched++; $display("FAIL reset_result got=%h %h want=0 0", rsp0Result, rsp1Result); end
    req0Valid = 1'b0; req1Valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One operation from requester 0: 15 + 10.
  task automatic test_single_op();
    req0Valid = 1'b1; req0SrcA = 32'd15; req0SrcB = 32'd10; req0AluControl = 3'b000;
    rsp0Ready = 1'b1; rsp1Ready = 1'b1;
    #1;
    nCompared++; if (req0Ready !== 1'b1 || req1Ready !== 1'b0) begin nMismatched++; $display("FAIL single_ready got=%b%b want=10", req0Ready, req1Ready); end
    @(posedge clk);
    @(negedge clk);
    req0Valid = 1'b0;
    nCompared++; if (aluSrcA !== 32'd15 || aluSrcB !== 32'd10 || aluControl !== 3'b000) begin nMismatched++; $display("FAIL single_exec_alu got=%0d %0d %b want=15 10 000", aluSrcA, aluSrcB, aluControl); end
    nCompared++; if (busy !== 1'b1 || rsp0Valid !== 1'b0 || req0Ready !== 1'b0) begin nMismatched++; $display("FAIL single_exec_ctl got=busy%b rsp%b rdy%b want=busy1 rsp0 rdy0", busy, rsp0Valid, req0Ready); end
    @(posedge clk);
    @(negedge clk);
    nCompared++; if (rsp0Valid !== 1'b1 || rsp0Result !== 32'd25) begin nMismatched++; $display("FAIL single_rsp got=%b %0d want=1 25", rsp0Valid, rsp0Result); end
    nCompared++; if (rsp1Valid !== 1'b0) begin nMismatched++; $display("FAIL single_rsp1_quiet got=%b want=0", rsp1Valid); end
    @(posedge clk);
    @(negedge clk);
    nCompared++; if (busy !== 1'b0 || rsp0Valid !== 1'b0) begin nMismatched++; $display("FAIL single_done got=busy%b rsp%b want=busy0 rsp0", busy, rsp0Valid); end
  endtask

  // Both requesters valid continuously from reset: grants must alternate.
  task automatic test_contention();
    logic [31:0] expRes [2];
    expRes[0] = 32'd15;
    expRes[1] = 32'hFFFFFFFF;
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    req0Valid = 1'b1; req0SrcA = 32'd20; req0SrcB = 32'd5; req0AluControl = 3'b001;
    req1Valid = 1'b1; req1SrcA = 32'hA5A5A5A5; req1SrcB = 32'h5A5A5A5A; req1AluControl = 3'b011;
    rsp0Ready = 1'b1; rsp1Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int own;
      own = i % 2;
      #1;
      nCompared++; if (req0Ready !== (own == 0) || req1Ready !== (own == 1)) begin nMismatched++; $display("FAIL contention_grant op%0d got=%b%b want_owner=%0d", i, req0Ready, req1Ready, own); end
      @(posedge clk);
      @(negedge clk);
      nCompared++; if (req0Ready !== 1'b0 || req1Ready !== 1'b0) begin nMismatched++; $display("FAIL contention_exec_ready op%0d got=%b%b want=00", i, req0Ready, req1Ready); end
      @(posedge clk);
      @(negedge clk);
      nCompared++; if (rsp0Valid !== (own == 0) || rsp1Valid !== (own == 1)) begin nMismatched++; $display("FAIL contention_rsp_port op%0d got=%b%b want_owner=%0d", i, rsp0Valid, rsp1Valid, own); end
      nCompared++; if (((own == 0) ? rsp0Result : rsp1Result) !== expRes[own]) begin nMismatched++; $display("FAIL contention_result op%0d got=%h want=%h", i, (own == 0) ? rsp0Result : rsp1Result, expRes[own]); end
      @(posedge clk);
      @(negedge clk);
    end
    req0Valid = 1'b0; req1Valid = 1'b0;
  endtask

  // Requester 1 stalls its response; requester 0 must wait it out.
  task automatic test_backpressure();
    req1Valid = 1'b1; req1SrcA = 32'hFFFFFFFB; req1SrcB = 32'd10; req1AluControl = 3'b101;
    rsp1Ready = 1'b0; rsp0Ready = 1'b1;
    #1;
    nCompared++; if (req1Ready !== 1'b1) begin nMismatched++; $display("FAIL bp_accept1 got=%b want=1", req1Ready); end
    @(posedge clk);
    @(negedge clk);
    req1Valid = 1'b0;
    req0Valid = 1'b1; req0SrcA = 32'd7; req0SrcB = 32'd3; req0AluControl = 3'b000;
    #1;
    nCompared++; if (req0Ready !== 1'b0 || busy !== 1'b1) begin nMismatched++; $display("FAIL bp_exec_wait got=rdy%b busy%b want=rdy0 busy1", req0Ready, busy); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      nCompared++; if (rsp1Valid !== 1'b1 || rsp1Result !== 32'd1 || busy !== 1'b1) begin nMismatched++; $display("FAIL bp_hold cyc%0d got=v%b r%0d busy%b want=v1 r1 busy1", i, rsp1Valid, rsp1Result, busy); end
      nCompared++; if (req0Ready !== 1'b0 || rsp0Valid !== 1'b0) begin nMismatched++; $display("FAIL bp_req0_blocked cyc%0d got=rdy%b rsp%b want=00", i, req0Ready, rsp0Valid); end
    end
    rsp1Ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp1Ready = 1'b0;
    #1;
    nCompared++; if (req0Ready !== 1'b1 || rsp1Valid !== 1'b0) begin nMismatched++; $display("FAIL bp_release got=rdy%b rsp1%b want=rdy1 rsp1_0", req0Ready, rsp1Valid); end
    @(posedge clk);
    @(negedge clk);
    req0Valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    nCompared++; if (rsp0Valid !== 1'b1 || rsp0Result !== 32'd10) begin nMismatched++; $display("FAIL bp_req0_result got=%b %0d want=1 10", rsp0Valid, rsp0Result); end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Opcodes other than add/sub are forwarded untouched to the ALU.
  task automatic test_passthrough();
    logic [31:0] vecA   [3];
    logic [31:0] vecB   [3];
    logic [2:0]  vecCtl [3];
    logic [31:0] vecExp [3];
    vecA[0] = 32'd1;         vecB[0] = 32'd4;         vecCtl[0] = 3'b110; vecExp[0] = 32'd16;
    vecA[1] = 32'd16;        vecB[1] = 32'd2;         vecCtl[1] = 3'b111; vecExp[1] = 32'd4;
    vecA[2] = 32'h12345678;  vecB[2] = 32'h87654321;  vecCtl[2] = 3'b100; vecExp[2] = 32'h87654321;
    rsp1Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req1Valid = 1'b1; req1SrcA = vecA[i]; req1SrcB = vecB[i]; req1AluControl = vecCtl[i];
      #1;
      nCompared++; if (req1Ready !== 1'b1) begin nMismatched++; $display("FAIL pass_accept op%0d got=%b want=1", i, req1Ready); end
      @(posedge clk);
      @(negedge clk);
      req1Valid = 1'b0;
      nCompared++; if (aluControl !== vecCtl[i] || aluSrcA !== vecA[i]) begin nMismatched++; $display("FAIL pass_aluctl op%0d got=%b %h want=%b %h", i, aluControl, aluSrcA, vecCtl[i], vecA[i]); end
      @(posedge clk);
      @(negedge clk);
      nCompared++; if (rsp1Valid !== 1'b1 || rsp1Result !== vecExp[i]) begin nMismatched++; $display("FAIL pass_result op%0d got=%b %h want=1 %h", i, rsp1Valid, rsp1Result, vecExp[i]); end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Asynchronous reset during EXEC abandons the operation.
  task automatic test_reset_mid_op();
    req0Valid = 1'b1; req0SrcA = 32'd15; req0SrcB = 32'd10; req0AluControl = 3'b000;
    rsp0Ready = 1'b0; rsp1Ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    nCompared++; if (busy !== 1'b1) begin nMismatched++; $display("FAIL midrst_in_exec got=%b want=1", busy); end
    req0SrcA = 32'd8; req0SrcB = 32'd2; req0AluControl = 3'b001;
    req1Valid = 1'b1; req1SrcA = 32'd3; req1SrcB = 32'd4; req1AluControl = 3'b000;
    #2 rst_n = 1'b0;
    #1;
    nCompared++; if (busy !== 1'b0 || req0Ready !== 1'b0 || req1Ready !== 1'b0 || rsp0Valid !== 1'b0 || rsp1Valid !== 1'b0) begin nMismatched++; $display("FAIL midrst_async got=busy%b rdy%b%b rsp%b%b want=all0", busy, req0Ready, req1Ready, rsp0Valid, rsp1Valid); end
    nCompared++; if (aluSrcA !== 32'h0 || rsp0Result !== 32'h0) begin nMismatched++; $display("FAIL midrst_clear got=%h %h want=0 0", aluSrcA, rsp0Result); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nCompared++; if (rsp0Valid !== 1'b0 || busy !== 1'b0) begin nMismatched++; $display("FAIL midrst_held cyc%0d got=rsp%b busy%b want=00", i, rsp0Valid, busy); end
    end
    rst_n = 1'b1;
    rsp0Ready = 1'b1; rsp1Ready = 1'b1;
    #1;
    nCompared++; if (req0Ready !== 1'b1 || req1Ready !== 1'b0) begin nMismatched++; $display("FAIL midrst_prio got=%b%b want=10", req0Ready, req1Ready); end
    @(posedge clk);
    @(negedge clk);
    req0Valid = 1'b0; req1Valid = 1'b0;
    nCompared++; if (rsp0Valid !== 1'b0 || aluSrcA !== 32'd8) begin nMismatched++; $display("FAIL midrst_new_exec got=rsp%b a%0d want=rsp0 a8", rsp0Valid, aluSrcA); end
    @(posedge clk);
    @(negedge clk);
    nCompared++; if (rsp0Valid !== 1'b1 || rsp0Result !== 32'd6) begin nMismatched++; $display("FAIL midrst_new_result got=%b %0d want=1 6", rsp0Valid, rsp0Result); end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    rst_n = 1'b0;
    req0Valid = 1'b0; req0SrcA = '0; req0SrcB = '0; req0AluControl = 3'b000;
    req1Valid = 1'b0; req1SrcA = '0; req1SrcB = '0; req1AluControl = 3'b000;
    rsp0Ready = 1'b0; rsp1Ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_passthrough();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
